mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and shared-memory channels of the memory port arbiter.
// The slave modport is the arbiter; the master modport is the surrounding core/memory.
interface mem_port_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one
// transaction in flight, with a per-transaction timeout that forces an error response.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q;
  logic        ptr_q;    // 1: LSU wins a tie
  logic        owner_q;  // 1: LSU owns the transaction
  logic [15:0] cnt_q;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        busy;
  logic        timeout;
  logic        complete;
  logic        resp_fire;
  logic        resp_err;
  logic [31:0] resp_rdata;

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE && !rst) begin
      grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || !ptr_q);
      grant_lsu = bus.lsu_req_valid && !grant_ifu;
    end
  end

  // cnt_q counts completed busy cycles, so +1 includes the current one.
  assign busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign timeout    = busy && (({16'd0, cnt_q} + 32'd1) >= TIMEOUT);
  assign complete   = (state_q == WAIT) && bus.mem_resp_valid;
  assign resp_fire  = complete || timeout;
  assign resp_err   = timeout && !complete;
  assign resp_rdata = complete ? bus.mem_rdata : 32'h0;

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;

  assign bus.ifu_resp_valid = resp_fire && !owner_q;
  assign bus.ifu_rdata      = bus.ifu_resp_valid ? resp_rdata : 32'h0;
  assign bus.ifu_resp_err   = bus.ifu_resp_valid && resp_err;
  assign bus.lsu_resp_valid = resp_fire && owner_q;
  assign bus.lsu_rdata      = bus.lsu_resp_valid ? resp_rdata : 32'h0;
  assign bus.lsu_resp_err   = bus.lsu_resp_valid && resp_err;

  assign bus.mem_req_valid  = (state_q == ISSUE) && !timeout;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 16'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ifu || grant_lsu) begin
            state_q <= ISSUE;
            owner_q <= grant_lsu;
            ptr_q   <= grant_ifu;
            cnt_q   <= 16'd0;
            addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q   <= grant_lsu && bus.lsu_wen;
            wdata_q <= grant_lsu ? bus.lsu_wdata : 32'h0;
            wmask_q <= grant_lsu ? bus.lsu_wmask : 4'h0;
          end
        end
        ISSUE: begin
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (timeout)                state_q <= IDLE;
          else if (bus.mem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (resp_fire) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
